// File: rtl/shared_pkg.sv
// shared_pkg: common types and helpers for the FIFO write-port arbiter.
//   arb_state_e  - arbiter FSM states (IDLE / BURST).
//   DEF_*        - default values for NUM_REQ, FIFO_WIDTH, MAX_BURST.
//   pick_t       - result of a round-robin pick (found flag + index).
//   rr_pick()    - scan-form round-robin pick: first set req bit starting at
//                  ptr and wrapping modulo n (n <= PICK_MAX).
package shared_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_FIFO_WIDTH = 16;
    localparam int unsigned DEF_MAX_BURST  = 4;

    localparam int unsigned PICK_MAX = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [PICK_MAX-1:0] req,
                                      input int unsigned ptr,
                                      input int unsigned n);
        pick_t       r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < PICK_MAX; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (!r.found && req[j[4:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[4:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin picker.
//   req_i   [NUM_REQ]  request vector
//   ptr_i   [IW]       highest-priority index this cycle
//   found_o            at least one request set
//   idx_o   [IW]       first set request at or after ptr_i (wrapping)
// Rotates req so ptr_i lands on bit 0, priority-encodes the lowest set bit,
// then adds ptr_i back modulo NUM_REQ.
module rr_priority_picker
    import shared_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic               found_o,
    output logic [IW-1:0]      idx_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IW-1:0]        enc;
    logic [IW:0]          sum;

    always_comb begin
        dbl     = {req_i, req_i} >> ptr_i;
        rot     = dbl[NUM_REQ-1:0];
        found_o = |rot;
        enc     = '0;
        // Descending scan so the lowest set bit is the one left in enc.
        for (int k = NUM_REQ; k > 0; k--) begin
            if (rot[k-1]) enc = IW'(k - 1);
        end
        sum   = {1'b0, enc} + {1'b0, ptr_i};
        idx_o = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ))
                                          : sum[IW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the sync FIFO write port between NUM_REQ requesters
// with round-robin arbitration and burst locking (up to MAX_BURST beats).
//   clk, rst          clock, synchronous active-high reset
//   req, req_data     per-requester request and packed data (slice i <-> req[i])
//   gnt               one-hot combinational grant; beat moves on req[i]&&gnt[i]
//   fifo_full,
//   fifo_almost_full  FIFO flags used for throttling
//   fifo_wr_en,
//   fifo_data_in      registered FIFO write (one cycle after grant)
//   owner, busy       current burst owner / high while in BURST
//   stall_cnt         (only with FIFO_WR_ARBITER_STATS_EN) saturating count of
//                     cycles with a pending request but no write allowed
module fifo_wr_arbiter
    import shared_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
`ifdef FIFO_WR_ARBITER_STATS_EN
    output logic [15:0]                   stall_cnt,
`endif
    output logic                          busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [BW-1:0] BURST_LEN = BW'(MAX_BURST);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         owner_q, owner_d, owner_nxt;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  wr_en_q;
    logic [FIFO_WIDTH-1:0] data_q, data_sel;
    logic [IW-1:0]         pick_ptr, pick_idx, gnt_idx;
    logic                  pick_found, can_write, owner_released;

    assign owner_nxt      = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
    // The registered write still in flight counts against the last free slot.
    assign can_write      = !fifo_full && !(wr_en_q && fifo_almost_full);
    assign owner_released = (state_q == ARB_BURST) && !req[owner_q];
    // On release the arbitration already uses the post-release pointer,
    // giving a zero-bubble handover.
    assign pick_ptr       = owner_released ? owner_nxt : rr_ptr_q;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i   (req),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        beat_d   = beat_q;
        gnt      = '0;
        gnt_idx  = owner_q;
        if (!rst && can_write) begin
            if (state_q == ARB_BURST && req[owner_q]) begin
                gnt[owner_q] = 1'b1;
                beat_d       = beat_q + BW'(1);
                if (beat_d == BURST_LEN) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = owner_nxt;
                end
            end else begin
                if (owner_released) begin
                    rr_ptr_d = owner_nxt;
                    state_d  = ARB_IDLE;
                end
                if (pick_found) begin
                    gnt[pick_idx] = 1'b1;
                    gnt_idx       = pick_idx;
                    owner_d       = pick_idx;
                    beat_d        = BW'(1);
                    if (MAX_BURST > 1) begin
                        state_d = ARB_BURST;
                    end else begin
                        rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
                    end
                end
            end
        end
        data_sel = req_data[gnt_idx*FIFO_WIDTH +: FIFO_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            beat_q   <= '0;
            wr_en_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            beat_q   <= beat_d;
            wr_en_q  <= |gnt;
            if (|gnt) data_q <= data_sel;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign owner        = owner_q;
    assign busy         = (state_q == ARB_BURST);

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (|req && !can_write && stall_q != '1) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '1;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic           fifo_full, fifo_almost_full, fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic [1:0]     owner;
    logic           busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0]    stall_cnt;
`endif

    always #5 clk = ~clk;

    // Environment FIFO occupancy (no data storage needed).
    int fcount = 0;
    bit rd_en  = 1'b0;
    assign fifo_full        = (fcount == DEPTH);
    assign fifo_almost_full = (fcount == DEPTH - 1);

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_data         (req_data),
        .gnt              (gnt),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_data_in     (fifo_data_in),
        .owner            (owner),
`ifdef FIFO_WR_ARBITER_STATS_EN
        .stall_cnt        (stall_cnt),
`endif
        .busy             (busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: burst owner bookkeeping in plain integers.
    bit           m_busy = 0, n_busy;
    int           m_owner = 0, m_beats = 0, m_ptr = 0, m_stall = 0;
    int           n_owner, n_beats, n_ptr, n_stall;
    bit           m_wr = 0, n_wr;
    logic [W-1:0] m_data = '0, n_data;
    logic [N-1:0] exp_gnt = '0;
    bit           wr_seen;

    task automatic model_eval();
        bit cw;
        int w;
        n_busy = m_busy; n_owner = m_owner; n_beats = m_beats; n_ptr = m_ptr;
        n_stall = m_stall; n_wr = 0; n_data = m_data; exp_gnt = '0;
        if (rst) begin
            n_busy = 0; n_owner = 0; n_beats = 0; n_ptr = 0;
            n_stall = 0; n_data = '0;
            return;
        end
        cw = !fifo_full && !(m_wr && fifo_almost_full);
        if (|req && !cw && n_stall < 65535) n_stall++;
        if (!cw) return;
        w = -1;
        if (m_busy && req[m_owner]) begin
            w = m_owner;
            n_beats = m_beats + 1;
            if (n_beats == MB) begin
                n_busy = 0;
                n_ptr  = (m_owner + 1) % N;
            end
        end else begin
            if (m_busy) begin
                n_ptr  = (m_owner + 1) % N;
                n_busy = 0;
            end
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(n_ptr + k) % N]) w = (n_ptr + k) % N;
            if (w >= 0) begin
                n_owner = w;
                n_beats = 1;
                if (MB > 1) n_busy = 1;
                else        n_ptr = (w + 1) % N;
            end
        end
        if (w >= 0) begin
            exp_gnt[w] = 1'b1;
            n_wr       = 1;
            n_data     = req_data[w*W +: W];
        end
    endtask

    task automatic tick();
        wr_seen = fifo_wr_en;
        @(posedge clk);
        #1;
        m_busy = n_busy; m_owner = n_owner; m_beats = n_beats; m_ptr = n_ptr;
        m_stall = n_stall; m_wr = n_wr; m_data = n_data;
        if (wr_seen && fcount < DEPTH) fcount++;
        if (rd_en && fcount > 0) fcount--;
        for (int i = 0; i < N; i++)
            if (exp_gnt[i]) req_data[i*W +: W] = W'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        model_eval();
        tick();
        rst    = 1'b0;
        fcount = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; rd_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            model_eval();
            tests_run += 4;
            if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
            if (fifo_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
            if (fifo_data_in !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h expected 0000", fifo_data_in); end
            if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
            tick();
        end
        rst = 1'b0; fcount = 0;
        @(negedge clk);
        model_eval();
        tests_run++;
        if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] e;
        do_reset();
        req = 4'b1111; rd_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            model_eval();
            e = 4'b0001 << ((c / MB) % N);
            tests_run += 2;
            if (gnt !== e) begin tests_failed++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt, e); end
            if (c > 0 && fifo_data_in !== m_data) begin tests_failed++; $display("FAIL rr_data c%0d: got %h expected %h", c, fifo_data_in, m_data); end
            tick();
        end
    endtask

    task automatic test_burst_lock();
        logic [N-1:0] seq [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                  4'b0100, 4'b0100, 4'b0100, 4'b0100};
        do_reset();
        req = 4'b0101; rd_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            model_eval();
            tests_run++;
            if (gnt !== seq[c]) begin tests_failed++; $display("FAIL burst_gnt c%0d: got %b expected %b", c, gnt, seq[c]); end
            if (c > 0) begin
                tests_run += 2;
                if (fifo_wr_en !== 1'b1) begin tests_failed++; $display("FAIL burst_bubble c%0d: got %b expected 1", c, fifo_wr_en); end
                if (owner !== 2'(m_owner)) begin tests_failed++; $display("FAIL burst_owner c%0d: got %0d expected %0d", c, owner, m_owner); end
            end
            tick();
        end
    endtask

    task automatic test_early_release();
        logic [N-1:0] rq [3] = '{4'b0010, 4'b1010, 4'b1001};
        logic [N-1:0] eg [3] = '{4'b0010, 4'b0010, 4'b1000};
        do_reset();
        rd_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req = rq[c];
            @(negedge clk);
            model_eval();
            tests_run++;
            if (gnt !== eg[c]) begin tests_failed++; $display("FAIL release_gnt c%0d: got %b expected %b", c, gnt, eg[c]); end
            tick();
        end
    endtask

    task automatic test_full_throttle();
        int writes;
        do_reset();
        fcount = 2; rd_en = 1'b0; req = 4'b0001; writes = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            model_eval();
            if (fifo_wr_en) writes++;
            tests_run += 3;
            if ((fifo_wr_en & fifo_full) !== 1'b0) begin tests_failed++; $display("FAIL full_overflow c%0d: got wr_en=1 full=1 expected no write", c); end
            if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL full_gnt c%0d: got %b expected %b", c, gnt, exp_gnt); end
            if (busy !== m_busy) begin tests_failed++; $display("FAIL full_busy c%0d: got %b expected %b", c, busy, m_busy); end
            tick();
        end
        tests_run += 2;
        if (writes != 6) begin tests_failed++; $display("FAIL full_writes: got %0d expected 6", writes); end
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL full_stall_busy: got %b expected 1", busy); end
`ifdef FIFO_WR_ARBITER_STATS_EN
        tests_run++;
        if (stall_cnt !== 16'(m_stall)) begin tests_failed++; $display("FAIL stall_cnt_full: got %0d expected %0d", stall_cnt, m_stall); end
`endif
        rd_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            model_eval();
            tests_run += 2;
            if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL resume_gnt c%0d: got %b expected %b", c, gnt, exp_gnt); end
            if (fifo_data_in !== m_data) begin tests_failed++; $display("FAIL resume_data c%0d: got %h expected %h", c, fifo_data_in, m_data); end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0100; rd_en = 1'b1;
        @(negedge clk);
        model_eval();
        tests_run++;
        if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL midrst_first: got %b expected 0100", gnt); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        model_eval();
        tests_run++;
        if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL midrst_gnt: got %b expected 0000", gnt); end
        tick();
        rst = 1'b0; req = 4'b1111; fcount = 0;
        @(negedge clk);
        model_eval();
        tests_run += 3;
        if (fifo_wr_en !== 1'b0) begin tests_failed++; $display("FAIL midrst_wr_en: got %b expected 0", fifo_wr_en); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL midrst_ptr: got %b expected 0001", gnt); end
`ifdef FIFO_WR_ARBITER_STATS_EN
        tests_run++;
        if (stall_cnt !== 16'h0000) begin tests_failed++; $display("FAIL midrst_stall: got %0d expected 0", stall_cnt); end
`endif
        tick();
    endtask

    task automatic test_random();
        do_reset();
        req = '0;
        for (int c = 0; c < 600; c++) begin
            rd_en = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            model_eval();
            tests_run += 5;
            if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, gnt, exp_gnt); end
            if (fifo_wr_en !== m_wr) begin tests_failed++; $display("FAIL rand_wr_en c%0d: got %b expected %b", c, fifo_wr_en, m_wr); end
            if (fifo_data_in !== m_data) begin tests_failed++; $display("FAIL rand_data c%0d: got %h expected %h", c, fifo_data_in, m_data); end
            if (busy !== m_busy) begin tests_failed++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy, m_busy); end
            if ((fifo_wr_en & fifo_full) !== 1'b0) begin tests_failed++; $display("FAIL rand_overflow c%0d: got write while full expected none", c); end
`ifdef FIFO_WR_ARBITER_STATS_EN
            tests_run++;
            if (stall_cnt !== 16'(m_stall)) begin tests_failed++; $display("FAIL rand_stall c%0d: got %0d expected %0d", c, stall_cnt, m_stall); end
`endif
            tick();
            for (int i = 0; i < N; i++) begin
                if (exp_gnt[i])  req[i] = ($urandom_range(0, 3) != 0);
                else if (req[i]) req[i] = ($urandom_range(0, 15) != 0);
                else             req[i] = ($urandom_range(0, 2) == 0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_early_release();
        test_full_throttle();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
